// File: rtl/ifetch.sv
// Instruction-fetch front end: owns the PC, drives the synchronous imem port and
// aligns each returned word with its PC into a registered decode-facing triple.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          REG_SIZE = 32
) (
    input  logic                clk,
    input  logic                reset,
    output logic [REG_SIZE-1:0] iaddr,
    input  logic [REG_SIZE-1:0] idata,
    input  logic                stall,
    input  logic                redirect,
    input  logic [REG_SIZE-1:0] redirect_pc,
    output logic [REG_SIZE-1:0] instr_out,
    output logic [REG_SIZE-1:0] pc_out,
    output logic                instr_valid
);

    logic [REG_SIZE-1:0] pc_f_q, pc_f_d;
    logic [REG_SIZE-1:0] req_pc_q, req_pc_d;
    logic                req_valid_q, req_valid_d;
    logic [REG_SIZE-1:0] instr_q, instr_d;
    logic [REG_SIZE-1:0] pc_out_q, pc_out_d;
    logic                valid_q, valid_d;
    logic [REG_SIZE-1:0] sel_pc;

    // While stalled, re-read the outstanding word so idata matches req_pc on release.
    assign sel_pc = stall ? req_pc_q : pc_f_q;
    assign iaddr  = {2'b00, sel_pc[REG_SIZE-1:2]};

    always_comb begin
        pc_f_d      = pc_f_q;
        req_pc_d    = req_pc_q;
        req_valid_d = req_valid_q;
        instr_d     = instr_q;
        pc_out_d    = pc_out_q;
        valid_d     = valid_q;
        if (redirect) begin
            pc_f_d      = {redirect_pc[REG_SIZE-1:2], 2'b00};
            req_valid_d = 1'b0;
            valid_d     = 1'b0;
        end else if (!stall) begin
            req_pc_d    = pc_f_q;
            req_valid_d = 1'b1;
            pc_f_d      = pc_f_q + REG_SIZE'(4);
            instr_d     = idata;
            pc_out_d    = req_pc_q;
            valid_d     = req_valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_q      <= RESET_PC;
            req_pc_q    <= '0;
            req_valid_q <= 1'b0;
            instr_q     <= '0;
            pc_out_q    <= '0;
            valid_q     <= 1'b0;
        end else begin
            pc_f_q      <= pc_f_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
            instr_q     <= instr_d;
            pc_out_q    <= pc_out_d;
            valid_q     <= valid_d;
        end
    end

    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: two instances (RESET_PC 0 and near-wrap) share stimulus and are
// checked every cycle against an abstract in-order fetch-stream model.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        reset, stall, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] iaddr0, iaddr1, idata0, idata1;
    logic [31:0] instr0, instr1, pcout0, pcout1;
    logic        vld0, vld1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ifetch #(.RESET_PC(32'h0000_0000), .REG_SIZE(32)) u_dut0 (
        .clk(clk), .reset(reset), .iaddr(iaddr0), .idata(idata0), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .instr_out(instr0),
        .pc_out(pcout0), .instr_valid(vld0));

    ifetch #(.RESET_PC(32'hFFFF_FFF8), .REG_SIZE(32)) u_dut1 (
        .clk(clk), .reset(reset), .iaddr(iaddr1), .idata(idata1), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .instr_out(instr1),
        .pc_out(pcout1), .instr_valid(vld1));

    // Synchronous instruction memory: mem[i] = 0x1000_0000 + i, one-cycle read.
    always @(posedge clk) begin
        idata0 <= 32'h1000_0000 + iaddr0;
        idata1 <= 32'h1000_0000 + iaddr1;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] byte_pc);
        return 32'h1000_0000 + (byte_pc >> 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Abstract model: the output is an in-order stream of consecutive PCs. After a
    // restart (reset/redirect) the first non-stalled edge only fills the pipe; each
    // later non-stalled edge emits the next PC. Stall freezes everything.
    logic [31:0] rst_pc   [2] = '{32'h0000_0000, 32'hFFFF_FFF8};
    logic [31:0] m_next   [2];
    logic [31:0] m_pc     [2];
    bit          m_filled [2];
    bit          m_vld    [2];
    bit          m_zero   [2];
    bit          m_c0     [2];

    task automatic model_edge(input bit r, input bit s, input bit rd, input logic [31:0] rpc);
        for (int d = 0; d < 2; d++) begin
            if (r) begin
                m_next[d] = rst_pc[d]; m_filled[d] = 0; m_vld[d] = 0;
                m_zero[d] = 1; m_c0[d] = 1;
            end else if (rd) begin
                m_next[d] = {rpc[31:2], 2'b00}; m_filled[d] = 0; m_vld[d] = 0;
                m_zero[d] = 0; m_c0[d] = 0;
            end else if (!s) begin
                m_zero[d] = 0; m_c0[d] = 0;
                if (m_filled[d]) begin
                    m_vld[d] = 1; m_pc[d] = m_next[d]; m_next[d] = m_next[d] + 32'd4;
                end else begin
                    m_filled[d] = 1; m_vld[d] = 0;
                end
            end else begin
                m_c0[d] = 0;
            end
        end
    endtask

    task automatic check_outputs();
        logic [31:0] a_pc [2];
        logic [31:0] a_in [2];
        logic [31:0] a_ia [2];
        logic        a_v  [2];
        a_pc = '{pcout0, pcout1}; a_in = '{instr0, instr1};
        a_ia = '{iaddr0, iaddr1}; a_v  = '{vld0, vld1};
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d valid", d), {31'd0, a_v[d]}, {31'd0, m_vld[d]});
            if (m_vld[d]) begin
                chk($sformatf("d%0d pc_out", d), a_pc[d], m_pc[d]);
                chk($sformatf("d%0d instr_out", d), a_in[d], mem_word(m_pc[d]));
            end
            if (m_zero[d]) begin
                chk($sformatf("d%0d rst pc_out", d), a_pc[d], 32'd0);
                chk($sformatf("d%0d rst instr_out", d), a_in[d], 32'd0);
            end
            if (m_c0[d] && !stall)
                chk($sformatf("d%0d c0 iaddr", d), a_ia[d], rst_pc[d] >> 2);
        end
    endtask

    task automatic cycle(input bit r, input bit s, input bit rd, input logic [31:0] rpc);
        reset = r; stall = s; redirect = rd; redirect_pc = rpc;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge(r, s, rd, rpc);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        for (int d = 0; d < 2; d++) begin
            m_next[d] = 0; m_pc[d] = 0; m_filled[d] = 0; m_vld[d] = 0; m_zero[d] = 0; m_c0[d] = 0;
        end
        @(posedge clk); model_edge(1, 0, 0, 0); #1;
        cycle(1, 0, 0, 0);
        // Restart, then stall 3 cycles while pc_out=8
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);                      // pc_out 12
        cycle(0, 1, 1, 32'h0000_0040);          // redirect at pc_out=16 edge... target 0x40
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
        cycle(0, 1, 1, 32'h0000_0103);          // redirect wins over stall, misaligned
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);                      // reset mid-stall
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 32'hFFFF_FFF6);          // redirect near wrap
        cycle(0, 1, 0, 0);                      // stall while invalid
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit r, s, rd;
            logic [31:0] t;
            r  = ($urandom_range(99) < 2);
            s  = ($urandom_range(99) < 25);
            rd = ($urandom_range(99) < 8);
            t  = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            cycle(r, s, rd, t);
        end
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
